pll_lock_detector: RTL and testbench

- Digital frequency-lock detector that consumes the divided feedback clock from the loop divider and compares it against the PLL reference clock.
- Both clocks are sampled in the fast system clock domain. Rising edges of each are counted over a programmable window of reference edges.
- Per window it reports the signed count difference and fast/slow flags. It asserts locked after a programmable number of consecutive in-tolerance windows.

---
 rtl/pll_pkg.sv | 13 +
 rtl/clk_edge_sync.sv | 26 ++
 rtl/pll_lock_detector.sv | 133 +++++++++++++
 tb/tb_pll_lock_detector.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// rtl/pll_pkg.sv - shared types and constants for the PLL frequency-lock detector
package pll_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_EVAL  = 2'd2
   } pll_state_t;

   localparam int PLL_CNT_W = 12;
   localparam int GOOD_W    = 4;

endpackage

// File: rtl/clk_edge_sync.sv
// rtl/clk_edge_sync.sv - multi-flop synchronizer for a slow clock input with a rising-edge pulse
module clk_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rstn_s,
   input  logic d,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk or negedge rstn_s) begin
      if (!rstn_s) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/pll_lock_detector.sv
// rtl/pll_lock_detector.sv - counts ref/feedback edges per window and reports diff, fast/slow and lock
module pll_lock_detector
   import pll_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = PLL_CNT_W
) (
   input  logic             clk,
   input  logic             rstn_s,
   input  logic             en,
   input  logic             ref_in,
   input  logic             fb_in,
   input  logic [CNT_W-1:0] win_len,
   input  logic [3:0]       tol,
   input  logic [3:0]       lock_cnt,
   output logic             locked,
   output logic             fb_fast,
   output logic             fb_slow,
   output logic             win_done,
   output logic [CNT_W:0]   diff_out
);

   logic              ref_rise;
   logic              fb_rise;
   pll_state_t        state_q;
   logic [CNT_W-1:0]  ref_cnt_q;
   logic [CNT_W-1:0]  fb_cnt_q;
   logic [CNT_W-1:0]  win_len_q;
   logic [3:0]        tol_q;
   logic [3:0]        lock_cnt_q;
   logic [GOOD_W-1:0] good_q;

   logic [CNT_W-1:0]  win_eff;
   logic [CNT_W-1:0]  ref_inc;
   logic [CNT_W-1:0]  fb_sat;
   logic signed [CNT_W:0] diff;
   logic signed [CNT_W:0] tol_s;
   logic              is_fast;
   logic              is_slow;
   logic [GOOD_W-1:0] good_nxt;
   logic              lock_nxt;
   logic              new_win_one;

   clk_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
      .clk    (clk),
      .rstn_s (rstn_s),
      .d      (ref_in),
      .rise   (ref_rise)
   );

   clk_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
      .clk    (clk),
      .rstn_s (rstn_s),
      .d      (fb_in),
      .rise   (fb_rise)
   );

   // A zero window length would never close, so it behaves as one edge.
   assign win_eff     = (win_len_q == '0) ? CNT_W'(1) : win_len_q;
   assign new_win_one = (win_len <= CNT_W'(1));
   assign ref_inc     = ref_cnt_q + CNT_W'(1);
   assign fb_sat      = (fb_cnt_q == '1) ? fb_cnt_q : fb_cnt_q + CNT_W'(1);

   assign diff     = $signed({1'b0, fb_cnt_q}) - $signed({1'b0, ref_cnt_q});
   assign tol_s    = $signed({{(CNT_W-3){1'b0}}, tol_q});
   assign is_fast  = (diff > tol_s);
   assign is_slow  = (diff < -tol_s);
   assign good_nxt = (is_fast || is_slow) ? '0 :
                     (good_q == '1)       ? good_q : good_q + GOOD_W'(1);
   assign lock_nxt = (lock_cnt_q != 4'd0) && (good_nxt >= lock_cnt_q);

   always_ff @(posedge clk or negedge rstn_s) begin
      if (!rstn_s) begin
         state_q    <= ST_IDLE;
         ref_cnt_q  <= '0;
         fb_cnt_q   <= '0;
         win_len_q  <= '0;
         tol_q      <= '0;
         lock_cnt_q <= '0;
         good_q     <= '0;
         locked     <= 1'b0;
         fb_fast    <= 1'b0;
         fb_slow    <= 1'b0;
         win_done   <= 1'b0;
         diff_out   <= '0;
      end else begin
         win_done <= 1'b0;
         if (!en) begin
            state_q   <= ST_IDLE;
            ref_cnt_q <= '0;
            fb_cnt_q  <= '0;
            good_q    <= '0;
            locked    <= 1'b0;
            fb_fast   <= 1'b0;
            fb_slow   <= 1'b0;
            diff_out  <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  ref_cnt_q  <= '0;
                  fb_cnt_q   <= '0;
                  win_len_q  <= win_len;
                  tol_q      <= tol;
                  lock_cnt_q <= lock_cnt;
                  state_q    <= ST_COUNT;
               end
               ST_COUNT: begin
                  if (ref_rise) ref_cnt_q <= ref_inc;
                  if (fb_rise)  fb_cnt_q  <= fb_sat;
                  if (ref_rise && (ref_inc == win_eff)) state_q <= ST_EVAL;
               end
               ST_EVAL: begin
                  win_done   <= 1'b1;
                  diff_out   <= diff;
                  fb_fast    <= is_fast;
                  fb_slow    <= is_slow;
                  good_q     <= good_nxt;
                  locked     <= lock_nxt;
                  // Edges seen while evaluating open the next window.
                  ref_cnt_q  <= CNT_W'(ref_rise);
                  fb_cnt_q   <= CNT_W'(fb_rise);
                  win_len_q  <= win_len;
                  tol_q      <= tol;
                  lock_cnt_q <= lock_cnt;
                  state_q    <= (ref_rise && new_win_one) ? ST_EVAL : ST_COUNT;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pll_lock_detector.sv
// tb/tb_pll_lock_detector.sv - randomized self-checking bench for pll_lock_detector against a window-level model
module tb_pll_lock_detector;

   localparam int SYNC = 2;
   localparam int CW   = 12;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rstn_s = 1'b0;
   logic          en = 1'b0;
   logic          ref_in = 1'b0;
   logic          fb_in = 1'b0;
   logic [CW-1:0] win_len = 12'd100;
   logic [3:0]    tol = 4'd2;
   logic [3:0]    lock_cnt = 4'd4;
   logic          locked;
   logic          fb_fast;
   logic          fb_slow;
   logic          win_done;
   logic [CW:0]   diff_out;

   int n_chk  = 0;
   int n_fail = 0;

   int cyc     = 0;
   int ref_per = 10;
   int ref_ph  = 0;
   int fb_per  = 10;
   int fb_ph   = 0;
   bit fb_stall = 1'b0;
   bit mon_en   = 1'b0;

   pll_lock_detector #(.SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
      .clk      (clk),
      .rstn_s   (rstn_s),
      .en       (en),
      .ref_in   (ref_in),
      .fb_in    (fb_in),
      .win_len  (win_len),
      .tol      (tol),
      .lock_cnt (lock_cnt),
      .locked   (locked),
      .fb_fast  (fb_fast),
      .fb_slow  (fb_slow),
      .win_done (win_done),
      .diff_out (diff_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int sdiff();
      return int'($signed(diff_out));
   endfunction

   // Square-wave sources for ref_in / fb_in, driven between active edges
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         ref_in = (((cyc + ref_ph) % ref_per) < (ref_per / 2));
         fb_in  = !fb_stall && (((cyc + fb_ph) % fb_per) < (fb_per / 2));
      end
   end

   // Reference model: an input rise is seen SYNC+1 samples later; windows are
   // counted in whole integers and the feedback count is clipped at the end.
   int m_hr[SYNC+1];
   int m_hf[SYNC+1];
   bit m_run, m_close, m_r, m_f;
   int m_rc, m_fc, m_wl, m_tl, m_lk, m_good, m_d;
   bit e_done, e_locked, e_fast, e_slow;
   int e_diff;

   always @(posedge clk or negedge rstn_s) begin
      if (!rstn_s) begin
         for (int i = 0; i <= SYNC; i++) begin
            m_hr[i] = 0;
            m_hf[i] = 0;
         end
         m_run = 0; m_close = 0; m_rc = 0; m_fc = 0; m_good = 0;
         e_done = 0; e_locked = 0; e_fast = 0; e_slow = 0; e_diff = 0;
      end else begin
         m_r = (m_hr[SYNC-1] == 1) && (m_hr[SYNC] == 0);
         m_f = (m_hf[SYNC-1] == 1) && (m_hf[SYNC] == 0);
         for (int i = SYNC; i > 0; i--) begin
            m_hr[i] = m_hr[i-1];
            m_hf[i] = m_hf[i-1];
         end
         m_hr[0] = int'(ref_in);
         m_hf[0] = int'(fb_in);
         e_done = 0;
         if (!en) begin
            m_run = 0; m_close = 0; m_rc = 0; m_fc = 0; m_good = 0;
            e_locked = 0; e_fast = 0; e_slow = 0; e_diff = 0;
         end else if (!m_run) begin
            m_run = 1; m_rc = 0; m_fc = 0;
            m_wl = (win_len == 0) ? 1 : int'(win_len);
            m_tl = int'(tol);
            m_lk = int'(lock_cnt);
         end else begin
            if (m_close) begin
               m_d = ((m_fc > CMAX) ? CMAX : m_fc) - m_rc;
               if (m_d <= m_tl && m_d >= -m_tl) m_good = (m_good >= 15) ? 15 : m_good + 1;
               else m_good = 0;
               e_done   = 1;
               e_diff   = m_d;
               e_fast   = (m_d > m_tl);
               e_slow   = (m_d < -m_tl);
               e_locked = (m_lk != 0) && (m_good >= m_lk);
               m_close = 0; m_rc = 0; m_fc = 0;
               m_wl = (win_len == 0) ? 1 : int'(win_len);
               m_tl = int'(tol);
               m_lk = int'(lock_cnt);
            end
            m_rc += int'(m_r);
            m_fc += int'(m_f);
            if (m_r && m_rc == m_wl) m_close = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en && rstn_s) begin
         check("win_done", int'(win_done), int'(e_done));
         check("locked", int'(locked), int'(e_locked));
         if (e_done) begin
            check("diff_out", sdiff(), e_diff);
            check("fb_fast", int'(fb_fast), int'(e_fast));
            check("fb_slow", int'(fb_slow), int'(e_slow));
         end
      end
   end

   task automatic wait_done(input int n, input int budget, input string tag);
      int seen;
      seen = 0;
      for (int i = 0; i < budget && seen < n; i++) begin
         @(negedge clk);
         if (win_done) seen++;
      end
      if (seen < n) check(tag, seen, n);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_locked"}, int'(locked), 0);
      check({tag, "_fast"}, int'(fb_fast), 0);
      check({tag, "_slow"}, int'(fb_slow), 0);
      check({tag, "_done"}, int'(win_done), 0);
      check({tag, "_diff"}, sdiff(), 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_all_zero("rst");
      rstn_s = 1'b1;
      mon_en = 1'b1;

      // Matched clocks: lock after four windows
      ref_ph = $urandom_range(0, 9);
      fb_ph  = $urandom_range(0, 9);
      repeat (5) @(negedge clk);
      en = 1'b1;
      wait_done(3, 4000, "t1_timeout");
      check("t1_lock_at3", int'(locked), 0);
      wait_done(1, 1500, "t1_timeout");
      check("t1_lock_at4", int'(locked), 1);
      check("t1_diff_rng", int'(sdiff() >= -1 && sdiff() <= 1), 1);
      check("t1_fast", int'(fb_fast), 0);
      check("t1_slow", int'(fb_slow), 0);
      wait_done(2, 2500, "t1_timeout");
      check("t1_lock_hold", int'(locked), 1);

      // Feedback about 10% fast
      fb_per = 9;
      wait_done(3, 4000, "t2_timeout");
      check("t2_fast", int'(fb_fast), 1);
      check("t2_slow", int'(fb_slow), 0);
      check("t2_diff_rng", int'(sdiff() >= 9 && sdiff() <= 13), 1);
      check("t2_lock", int'(locked), 0);

      // Relock, stall feedback for one window, relock again
      fb_per = 10;
      wait_done(6, 7000, "t3_timeout");
      check("t3_lock", int'(locked), 1);
      fb_stall = 1'b1;
      wait_done(1, 1500, "t3_timeout");
      fb_stall = 1'b0;
      check("t3_slow", int'(fb_slow), 1);
      check("t3_fast", int'(fb_fast), 0);
      check("t3_lock_drop", int'(locked), 0);
      check("t3_diff_rng", int'(sdiff() >= -100 && sdiff() <= -98), 1);
      wait_done(3, 3500, "t3_timeout");
      check("t3_relock_at3", int'(locked), 0);
      wait_done(1, 1500, "t3_timeout");
      check("t3_relock_at4", int'(locked), 1);

      // Feedback edge one cycle after each closing ref edge lands in EVAL
      en = 1'b0;
      ref_ph  = $urandom_range(1, 9);
      fb_ph   = ref_ph - 1;
      win_len = 12'd4;
      tol     = 4'd0;
      lock_cnt = 4'd2;
      repeat (4) @(negedge clk);
      en = 1'b1;
      wait_done(3, 300, "t4_timeout");
      check("t4_diff_eval", sdiff(), 0);
      check("t4_lock", int'(locked), 1);

      // Abort mid-window, then restart
      repeat (7) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      check_all_zero("t5_abort");
      repeat (10) @(negedge clk);
      en = 1'b1;
      wait_done(2, 300, "t5_timeout");

      // Randomized rounds, including lock_cnt=0 and win_len=0
      for (int r = 0; r < 4; r++) begin
         ref_per  = $urandom_range(4, 16);
         fb_per   = ref_per + $urandom_range(0, 2);
         ref_ph   = $urandom_range(0, 15);
         fb_ph    = $urandom_range(0, 15);
         win_len  = CW'($urandom_range(0, 20));
         tol      = 4'($urandom_range(0, 3));
         lock_cnt = (r == 0) ? 4'd0 : 4'($urandom_range(1, 3));
         for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) begin
               en = 1'b0;
               repeat ($urandom_range(1, 5)) @(negedge clk);
               en = 1'b1;
            end
         end
      end

      // Feedback counter saturation, then asynchronous reset mid-window
      en = 1'b0;
      ref_per = 40; ref_ph = 0;
      fb_per = 4;   fb_ph = 1;
      win_len = 12'd500; tol = 4'd2; lock_cnt = 4'd4;
      repeat (3) @(negedge clk);
      en = 1'b1;
      wait_done(1, 25000, "t6_timeout");
      check("t6_sat_diff", sdiff(), CMAX - 500);
      check("t6_fast", int'(fb_fast), 1);
      repeat (3000) @(negedge clk);
      #3;
      rstn_s = 1'b0;
      #1;
      check_all_zero("t6_async_rst");
      @(negedge clk);
      rstn_s = 1'b1;
      repeat (100) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
